// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - access-size encodings carried on MemDataSel
//   - LSU FSM state encodings
//   - byte-enable lookup constants for the 32-bit data bus
package mips_mem_pkg;

    localparam logic [2:0] SEL_WORD  = 3'b000;
    localparam logic [2:0] SEL_BYTE  = 3'b001;
    localparam logic [2:0] SEL_HALF  = 3'b010;
    localparam logic [2:0] SEL_BYTEU = 3'b011;
    localparam logic [2:0] SEL_HALFU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Unused size codes fall through to word behaviour.
    function automatic logic sel_is_byte(input logic [2:0] sel);
        return (sel == SEL_BYTE) || (sel == SEL_BYTEU);
    endfunction

    function automatic logic sel_is_half(input logic [2:0] sel);
        return (sel == SEL_HALF) || (sel == SEL_HALFU);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// load_extend: picks the addressed byte/half lane out of a bus read word and
// sign- or zero-extends it to the full data width. Purely combinational.
// Ports:
//   rdata     in   bus read word
//   byte_off  in   address bits [1:0] of the access
//   data_sel  in   access size / signedness code
//   ext_data  out  extended load result
module load_extend
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            byte_off,
    input  logic [2:0]            data_sel,
    output logic [DATA_WIDTH-1:0] ext_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (byte_off)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase

        half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];

        case (data_sel)
            SEL_BYTE:  ext_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            SEL_BYTEU: ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
            SEL_HALF:  ext_data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            SEL_HALFU: ext_data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            default:   ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit. Issues one req/ack bus access per
// load/store, aligns store data onto byte lanes, extends load data for MEM/WB,
// and stalls the pipeline until the access completes, times out or is
// rejected as misaligned.
//
// state | meaning
// IDLE  | no bus activity; accept a new access from EX/MEM
// REQ   | request on the bus, waiting for ack or timeout
// DONE  | one-cycle release: stall drops so MEM/WB latches o_ReadDataM
//
// Ports:
//   i_CLK, i_RST                 clock, synchronous active-high reset
//   i_ALUOutM, i_WriteDataM      effective address, right-justified store data
//   i_MemReadM, i_MemWriteM      load / store in MEM (both = store)
//   i_MemDataSelM                access size and signedness
//   o_MemReq/We/Addr/WData/BE    data-memory bus request side
//   i_MemAck, i_MemRData         bus completion strobe and read word
//   o_ReadDataM                  extended load data to MEM/WB
//   o_StallM                     pipeline freeze
//   o_MisalignM, o_BusErrM       one-cycle error pulses
module mem_stage_lsu
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [ADDRESS_WIDTH-1:0] i_ALUOutM,
    input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
    input  logic                     i_MemReadM,
    input  logic                     i_MemWriteM,
    input  logic [2:0]               i_MemDataSelM,
    output logic                     o_MemReq,
    output logic                     o_MemWe,
    output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0]    o_MemWData,
    output logic [3:0]               o_MemBE,
    input  logic                     i_MemAck,
    input  logic [DATA_WIDTH-1:0]    i_MemRData,
    output logic [DATA_WIDTH-1:0]    o_ReadDataM,
    output logic                     o_StallM,
    output logic                     o_MisalignM,
    output logic                     o_BusErrM
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e state_q, state_d;

    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            off_q;
    logic [2:0]            sel_q;
    logic                  access;
    logic                  is_byte;
    logic                  is_half;
    logic                  misaligned;
    logic                  timeout;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] ext_data;

    assign access     = i_MemReadM | i_MemWriteM;
    assign is_byte    = sel_is_byte(i_MemDataSelM);
    assign is_half    = sel_is_half(i_MemDataSelM);
    assign misaligned = (is_half & i_ALUOutM[0]) |
                        (~is_byte & ~is_half & (i_ALUOutM[1:0] != 2'b00));
    assign timeout    = (state_q == ST_REQ) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    assign o_MemReq = (state_q == ST_REQ);
    assign o_StallM = ((state_q == ST_IDLE) & access & ~misaligned) | (state_q == ST_REQ);

    // Store lane alignment; loads always request the full word.
    always_comb begin
        be_d    = BE_WORD;
        wdata_d = i_WriteDataM;
        if (is_byte) begin
            wdata_d = {4{i_WriteDataM[7:0]}};
            if (i_MemWriteM) be_d = BE_BYTE0 << i_ALUOutM[1:0];
        end else if (is_half) begin
            wdata_d = {2{i_WriteDataM[15:0]}};
            if (i_MemWriteM) be_d = i_ALUOutM[1] ? BE_HALF_HI : BE_HALF_LO;
        end
    end

    load_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extend (
        .rdata    (i_MemRData),
        .byte_off (off_q),
        .data_sel (sel_q),
        .ext_data (ext_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (access && !misaligned) state_d = ST_REQ;
            ST_REQ:  if (i_MemAck || timeout)   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            sel_q       <= SEL_WORD;
            o_MemWe     <= 1'b0;
            o_MemAddr   <= '0;
            o_MemWData  <= '0;
            o_MemBE     <= '0;
            o_ReadDataM <= '0;
            o_MisalignM <= 1'b0;
            o_BusErrM   <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_MisalignM <= 1'b0;
            o_BusErrM   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (access) begin
                        o_ReadDataM <= '0;
                        if (misaligned) begin
                            o_MisalignM <= 1'b1;
                        end else begin
                            o_MemAddr  <= {i_ALUOutM[ADDRESS_WIDTH-1:2], 2'b00};
                            o_MemWe    <= i_MemWriteM;
                            o_MemBE    <= be_d;
                            o_MemWData <= wdata_d;
                            off_q      <= i_ALUOutM[1:0];
                            sel_q      <= i_MemDataSelM;
                        end
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Ack takes priority over a coincident timeout.
                    if (i_MemAck) begin
                        o_ReadDataM <= o_MemWe ? '0 : ext_data;
                    end else if (timeout) begin
                        o_BusErrM   <= 1'b1;
                        o_ReadDataM <= '0;
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic [31:0] i_ALUOutM;
    logic [31:0] i_WriteDataM;
    logic        i_MemReadM;
    logic        i_MemWriteM;
    logic [2:0]  i_MemDataSelM;
    logic        o_MemReq;
    logic        o_MemWe;
    logic [31:0] o_MemAddr;
    logic [31:0] o_MemWData;
    logic [3:0]  o_MemBE;
    logic        i_MemAck;
    logic [31:0] i_MemRData;
    logic [31:0] o_ReadDataM;
    logic        o_StallM;
    logic        o_MisalignM;
    logic        o_BusErrM;

    int tests = 0;
    int fails = 0;

    mem_stage_lsu #(
        .DATA_WIDTH     (32),
        .ADDRESS_WIDTH  (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_CLK         (i_CLK),
        .i_RST         (i_RST),
        .i_ALUOutM     (i_ALUOutM),
        .i_WriteDataM  (i_WriteDataM),
        .i_MemReadM    (i_MemReadM),
        .i_MemWriteM   (i_MemWriteM),
        .i_MemDataSelM (i_MemDataSelM),
        .o_MemReq      (o_MemReq),
        .o_MemWe       (o_MemWe),
        .o_MemAddr     (o_MemAddr),
        .o_MemWData    (o_MemWData),
        .o_MemBE       (o_MemBE),
        .i_MemAck      (i_MemAck),
        .i_MemRData    (i_MemRData),
        .o_ReadDataM   (o_ReadDataM),
        .o_StallM      (o_StallM),
        .o_MisalignM   (o_MisalignM),
        .o_BusErrM     (o_BusErrM)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    // Runs one aligned access. The bus model acks on the ack_on-th REQ cycle
    // (0 = never). Returns what was observed; callers compare.
    task automatic do_access(
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic        rd,
        input  logic        wr,
        input  logic [2:0]  sel,
        input  int          ack_on,
        input  logic [31:0] rdata,
        output int          stalls,
        output int          reqs,
        output int          errs,
        output logic        done_seen,
        output logic [31:0] done_data,
        output logic [31:0] bus_addr,
        output logic [31:0] bus_wdata,
        output logic [3:0]  bus_be,
        output logic        bus_we
    );
        stalls    = 0;
        reqs      = 0;
        errs      = 0;
        done_seen = 1'b0;
        done_data = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_be    = '0;
        bus_we    = 1'b0;
        i_ALUOutM     = addr;
        i_WriteDataM  = wdata;
        i_MemReadM    = rd;
        i_MemWriteM   = wr;
        i_MemDataSelM = sel;
        i_MemAck      = 1'b0;
        #1;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            if (o_StallM)  stalls++;
            if (o_BusErrM) errs++;
            if (o_MemReq) begin
                reqs++;
                bus_addr  = o_MemAddr;
                bus_wdata = o_MemWData;
                bus_be    = o_MemBE;
                bus_we    = o_MemWe;
                i_MemRData = rdata;
                i_MemAck   = (reqs == ack_on);
            end else if (reqs > 0) begin
                done_seen = 1'b1;
                done_data = o_ReadDataM;
            end
            tick();
            i_MemAck = 1'b0;
        end
        i_MemReadM  = 1'b0;
        i_MemWriteM = 1'b0;
        tests++;
        if (!done_seen) begin
            fails++;
            $display("FAIL access_timeout addr=%h: no DONE within 40 cycles (reqs=%0d)", addr, reqs);
        end
    endtask

    task automatic test_reset();
        i_RST = 1'b1;
        i_ALUOutM = '0; i_WriteDataM = '0; i_MemReadM = 1'b0; i_MemWriteM = 1'b0;
        i_MemDataSelM = 3'b000; i_MemAck = 1'b0; i_MemRData = '0;
        tick(); tick();
        i_RST = 1'b0;
        #1;
        tests++;
        if ({o_MemReq, o_MemWe, o_MemBE, o_StallM, o_MisalignM, o_BusErrM} !== 9'b0 ||
            o_MemAddr !== 32'h0 || o_MemWData !== 32'h0 || o_ReadDataM !== 32'h0) begin
            fails++;
            $display("FAIL reset_state req=%b we=%b be=%b stall=%b mis=%b err=%b addr=%h wd=%h rd=%h want all 0",
                     o_MemReq, o_MemWe, o_MemBE, o_StallM, o_MisalignM, o_BusErrM, o_MemAddr, o_MemWData, o_ReadDataM);
        end
        tick();
    endtask

    task automatic test_load_word();
        int st, rq, er; logic dn; logic [31:0] dd, ba, bw; logic [3:0] be; logic we;
        do_access(32'h100, 32'h0, 1, 0, 3'b000, 1, 32'hDEADBEEF, st, rq, er, dn, dd, ba, bw, be, we);
        tests++;
        if (ba !== 32'h100 || be !== 4'b1111 || we !== 1'b0) begin
            fails++; $display("FAIL lw_bus addr=%h be=%b we=%b want 00000100 1111 0", ba, be, we);
        end
        tests++;
        if (st != 2) begin fails++; $display("FAIL lw_stall got %0d want 2", st); end
        tests++;
        if (dd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data got %h want deadbeef", dd); end
    endtask

    task automatic test_load_subword();
        int st, rq, er; logic dn; logic [31:0] dd, ba, bw; logic [3:0] be; logic we;
        do_access(32'h103, 32'h0, 1, 0, 3'b001, 1, 32'h80112233, st, rq, er, dn, dd, ba, bw, be, we);
        tests++;
        if (dd !== 32'hFFFFFF80 || ba !== 32'h100) begin
            fails++; $display("FAIL lb_signed got %h addr=%h want ffffff80 00000100", dd, ba);
        end
        do_access(32'h103, 32'h0, 1, 0, 3'b011, 1, 32'h80112233, st, rq, er, dn, dd, ba, bw, be, we);
        tests++;
        if (dd !== 32'h00000080) begin fails++; $display("FAIL lbu got %h want 00000080", dd); end
        do_access(32'h101, 32'h0, 1, 0, 3'b001, 1, 32'h80112233, st, rq, er, dn, dd, ba, bw, be, we);
        tests++;
        if (dd !== 32'h00000022) begin fails++; $display("FAIL lb_lane1 got %h want 00000022", dd); end
        do_access(32'h102, 32'h0, 1, 0, 3'b100, 1, 32'h80112233, st, rq, er, dn, dd, ba, bw, be, we);
        tests++;
        if (dd !== 32'h00008011) begin fails++; $display("FAIL lhu_hi got %h want 00008011", dd); end
        do_access(32'h100, 32'h0, 1, 0, 3'b010, 1, 32'h1234F00D, st, rq, er, dn, dd, ba, bw, be, we);
        tests++;
        if (dd !== 32'hFFFFF00D) begin fails++; $display("FAIL lh_lo got %h want fffff00d", dd); end
    endtask

    task automatic test_store();
        int st, rq, er; logic dn; logic [31:0] dd, ba, bw; logic [3:0] be; logic we;
        do_access(32'h202, 32'h1234ABCD, 0, 1, 3'b010, 3, 32'hFFFFFFFF, st, rq, er, dn, dd, ba, bw, be, we);
        tests++;
        if (be !== 4'b1100 || bw !== 32'hABCDABCD || we !== 1'b1 || ba !== 32'h200) begin
            fails++; $display("FAIL sh_bus be=%b wd=%h we=%b addr=%h want 1100 abcdabcd 1 00000200", be, bw, we, ba);
        end
        tests++;
        if (st != 4) begin fails++; $display("FAIL sh_stall got %0d want 4", st); end
        tests++;
        if (dd !== 32'h0) begin fails++; $display("FAIL sh_readdata got %h want 00000000", dd); end
        // both read and write high is a store
        do_access(32'h201, 32'h000000AB, 1, 1, 3'b001, 1, 32'h0, st, rq, er, dn, dd, ba, bw, be, we);
        tests++;
        if (be !== 4'b0010 || bw !== 32'hABABABAB || we !== 1'b1 || ba !== 32'h200) begin
            fails++; $display("FAIL sb_bus be=%b wd=%h we=%b addr=%h want 0010 abababab 1 00000200", be, bw, we, ba);
        end
        do_access(32'h300, 32'hCAFEF00D, 0, 1, 3'b000, 2, 32'h0, st, rq, er, dn, dd, ba, bw, be, we);
        tests++;
        if (be !== 4'b1111 || bw !== 32'hCAFEF00D || st != 3) begin
            fails++; $display("FAIL sw_bus be=%b wd=%h stall=%0d want 1111 cafef00d 3", be, bw, st);
        end
    endtask

    task automatic test_misalign();
        int reqs = 0, pulses = 0;
        i_ALUOutM = 32'h101; i_MemReadM = 1'b1; i_MemWriteM = 1'b0; i_MemDataSelM = 3'b000;
        #1;
        tests++;
        if (o_StallM !== 1'b0) begin fails++; $display("FAIL mis_stall got %b want 0", o_StallM); end
        if (o_MemReq) reqs++;
        tick();
        i_MemReadM = 1'b0;
        tests++;
        if (o_MisalignM !== 1'b1 || o_ReadDataM !== 32'h0) begin
            fails++; $display("FAIL mis_pulse mis=%b rd=%h want 1 00000000", o_MisalignM, o_ReadDataM);
        end
        for (int i = 0; i < 3; i++) begin
            if (o_MemReq) reqs++;
            tick();
            if (o_MisalignM) pulses++;
        end
        tests++;
        if (reqs != 0 || pulses != 0) begin
            fails++; $display("FAIL mis_quiet reqs=%0d extra_pulses=%0d want 0 0", reqs, pulses);
        end
        // half store at odd address
        i_ALUOutM = 32'h203; i_MemWriteM = 1'b1; i_MemDataSelM = 3'b010;
        #1;
        if (o_MemReq) reqs++;
        tick();
        i_MemWriteM = 1'b0;
        tests++;
        if (o_MisalignM !== 1'b1 || o_MemReq !== 1'b0) begin
            fails++; $display("FAIL mis_half mis=%b req=%b want 1 0", o_MisalignM, o_MemReq);
        end
        tick();
    endtask

    task automatic test_timeout();
        int st, rq, er; logic dn; logic [31:0] dd, ba, bw; logic [3:0] be; logic we;
        do_access(32'h400, 32'h0, 1, 0, 3'b000, 0, 32'h55AA55AA, st, rq, er, dn, dd, ba, bw, be, we);
        tests++;
        if (rq != 16 || er != 1 || dd !== 32'h0) begin
            fails++; $display("FAIL timeout reqs=%0d errs=%0d data=%h want 16 1 00000000", rq, er, dd);
        end
        tests++;
        if (o_BusErrM !== 1'b0) begin fails++; $display("FAIL timeout_pulse err=%b want 0 after one cycle", o_BusErrM); end
        do_access(32'h400, 32'h0, 1, 0, 3'b000, 16, 32'h55AA55AA, st, rq, er, dn, dd, ba, bw, be, we);
        tests++;
        if (rq != 16 || er != 0 || dd !== 32'h55AA55AA || o_BusErrM !== 1'b0) begin
            fails++; $display("FAIL ack_at_limit reqs=%0d errs=%0d data=%h want 16 0 55aa55aa", rq, er, dd);
        end
    endtask

    task automatic test_reset_mid_req();
        int errs = 0;
        i_ALUOutM = 32'h500; i_WriteDataM = 32'h11223344; i_MemReadM = 1'b0; i_MemWriteM = 1'b1;
        i_MemDataSelM = 3'b000;
        tick();                 // first REQ cycle
        tick();                 // second REQ cycle
        tests++;
        if (o_MemReq !== 1'b1) begin fails++; $display("FAIL rst_pre req=%b want 1", o_MemReq); end
        i_RST = 1'b1;
        tick();
        i_RST = 1'b0; i_MemWriteM = 1'b0;
        #1;
        tests++;
        if ({o_MemReq, o_MemWe, o_MemBE, o_StallM, o_MisalignM, o_BusErrM} !== 9'b0 ||
            o_MemAddr !== 32'h0 || o_MemWData !== 32'h0 || o_ReadDataM !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid req=%b we=%b be=%b stall=%b addr=%h wd=%h rd=%h want all 0",
                     o_MemReq, o_MemWe, o_MemBE, o_StallM, o_MemAddr, o_MemWData, o_ReadDataM);
        end
        i_MemAck = 1'b1; i_MemRData = 32'hFFFFFFFF;
        tick();
        i_MemAck = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_BusErrM || o_MemReq || o_StallM || o_ReadDataM != 32'h0) errs++;
            tick();
        end
        tests++;
        if (errs != 0) begin fails++; $display("FAIL stray_ack changed outputs in %0d cycles want 0", errs); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_subword();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit of the MEM stage. It sits directly upstream of the MEM/WB pipeline register and produces the read data that register latches.
- Takes the EX/MEM address, store data and access size. Drives a req/ack data-memory bus and generates byte enables and lane-aligned store data.
- Extracts and sign- or zero-extends load data.
- Stalls the pipeline until the bus transaction completes, times out, or is rejected as misaligned.

Parameters:
- DATA_WIDTH, 32, data and bus width (fixed at 32 for lane logic).
- ADDRESS_WIDTH, 32, memory address width.
- TIMEOUT_CYCLES, 16, maximum REQ cycles before the access is abandoned (must be ≥2).

Ports:
- i_CLK  in  1  clock, single domain.
- i_RST  in  1  synchronous, active-high reset.
- i_ALUOutM  in  ADDRESS_WIDTH  effective address.
- i_WriteDataM  in  DATA_WIDTH  store data, right-justified.
- i_MemReadM  in  1  load in MEM.
- i_MemWriteM  in  1  store in MEM.
- i_MemDataSelM  in  3  size: 000 word, 001 byte signed, 010 half signed, 011 byte unsigned, 100 half unsigned; others treated as word.
- o_MemReq  out  1  bus request.
- o_MemWe  out  1  bus write enable.
- o_MemAddr  out  ADDRESS_WIDTH  word-aligned bus address ([1:0]=00).
- o_MemWData  out  DATA_WIDTH  lane-replicated store data.
- o_MemBE  out  4  byte enables.
- i_MemAck  in  1  one-cycle completion strobe.
- i_MemRData  in  DATA_WIDTH  bus read word, valid with i_MemAck.
- o_ReadDataM  out  DATA_WIDTH  extended load data to MEM/WB.
- o_StallM  out  1  freeze IF..MEM, bubble into WB.
- o_MisalignM  out  1  misaligned-access pulse.
- o_BusErrM  out  1  timeout pulse.

Behaviour:
- Reset is synchronous. State=IDLE. o_MemReq, o_MemWe, o_MemAddr, o_MemWData, o_MemBE, o_ReadDataM, o_MisalignM, o_BusErrM and the timeout counter all go to 0. Reset during REQ drops o_MemReq at that edge; a later ack is ignored.
- access = i_MemReadM | i_MemWriteM. Both high at once is treated as a store.
- misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - access & ~misaligned → at the edge, register addr/BE/WData/We, assert o_MemReq, go to REQ.
  - access & misaligned → o_MisalignM=1 for one cycle (registered), no request, no stall, o_ReadDataM=0, stay IDLE.
- REQ:
  - Bus outputs are held stable and o_MemReq=1.
  - Counter increments each cycle.
  - i_MemAck → capture extended read data into o_ReadDataM (loads only; stores leave it 0), drop o_MemReq, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack → drop o_MemReq, pulse o_BusErrM, o_ReadDataM=0, go to DONE.
  - Ack and timeout in the same cycle: ack wins, no o_BusErrM.
- DONE: lasts one cycle, o_StallM=0 so MEM/WB latches o_ReadDataM and the pipeline advances. Returns to IDLE. Never re-issues.
- o_StallM (combinational) = (state==IDLE & access & ~misaligned) | (state==REQ).
- Minimum load latency: the access cycle, 1 REQ cycle (ack on first REQ cycle), then DONE, for 2 stall cycles.
- i_MemAck outside REQ is ignored.
- Store lanes:
  - byte → BE=1<<addr[1:0], data byte replicated x4.
  - half → BE=addr[1]?1100:0011, half replicated x2.
  - word → BE=1111.
  - Loads drive BE=1111, We=0.
- Load extract: select the lane by addr[1:0]/addr[1], then sign- or zero-extend per i_MemDataSelM.

Decomposition:
- Shared package mips_mem_pkg: MemDataSel encodings, FSM state encodings, the BE lookup constants.
- One combinational sub-module, load_extend, handles lane select and sign/zero extension. The FSM, counter and store alignment stay in mem_stage_lsu.

Test Plan:
1. Load word from addr 0x100, ack on first REQ cycle, RData=0xDEADBEEF → o_MemAddr=0x100, BE=1111, stall exactly 2 cycles, o_ReadDataM=0xDEADBEEF in DONE.
2. Signed byte load from addr 0x103, RData=0x80112233 → o_ReadDataM=0xFFFFFF80. Same load as unsigned → 0x00000080.
3. Store half 0x1234ABCD to addr 0x202, ack after 3 REQ cycles → BE=1100, WData=0xABCDABCD, We=1, o_MemAddr=0x200, stall 4 cycles.
4. Word load at addr 0x101 → o_MisalignM one-cycle pulse, o_MemReq never asserted, o_StallM=0.
5. Load with ack withheld, TIMEOUT_CYCLES=16 → o_MemReq high 16 cycles then low, o_BusErrM one pulse, o_ReadDataM=0. Rerun with ack on the 16th REQ cycle → no o_BusErrM, data captured.
6. Assert i_RST during the 2nd REQ cycle → next cycle o_MemReq=0, state IDLE, all outputs 0. A stray ack after reset causes no output change.
